conv_window_gen: RTL and testbench

Streaming window generator that feeds the `conv` datapath. It accepts a raster-order stream of 32-bit pixels, one per handshake. It keeps the last SIZE-1 image rows in line buffers and emits every fully-populated SIZE×SIZE window as the flattened array `conv` consumes on its `conv_input` port. It sits between the pixel source and the FMA-chain convolution, and only valid windows are produced (no border padding).

---
 rtl/conv_pkg.sv | 15 +
 rtl/conv_line_buffer.sv | 29 ++
 rtl/conv_window_gen.sv | 124 ++++++++++++
 tb/tb_conv_window_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ---- conv_pkg : shared pixel type and window indexing for conv and its feeders (rev 1.0) ----
package conv_pkg;

   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] pixel_t;

   // Flattened window position of row r, column c in a size x size window.
   function automatic int win_idx(input int r, input int c, input int size);
      return r * size + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ---- conv_line_buffer : one image row of storage, combinational read-before-write (rev 1.0) ----
module conv_line_buffer
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Read returns the pre-write word so the cascade can shift in one cycle.
   assign o_rdata = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ---- conv_window_gen : raster pixel stream to SIZE x SIZE valid-only windows (rev 1.0) ----
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int SIZE   = 7,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int DATA_W = conv_pkg::DATA_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [DATA_W-1:0] win_data [SIZE*SIZE],
   output logic              win_last
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [CW-1:0] c_COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] c_ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0] c_COL_EMIT = CW'(SIZE - 1);
   localparam logic [RW-1:0] c_ROW_EMIT = RW'(SIZE - 1);

   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [DATA_W-1:0] r_win [SIZE*SIZE];
   logic              r_valid;
   logic              r_last;

   logic              w_accept;
   logic              w_emit;
   logic              w_col_wrap;
   logic              w_frame_end;
   logic [DATA_W-1:0] w_lb_rd [SIZE-1];
   logic [DATA_W-1:0] w_lb_wr [SIZE-1];

   assign in_ready    = !r_valid || win_ready;
   assign w_accept    = in_valid && in_ready;
   assign w_col_wrap  = (r_col == c_COL_LAST);
   assign w_frame_end = w_col_wrap && (r_row == c_ROW_LAST);
   assign w_emit      = w_accept && (r_row >= c_ROW_EMIT) && (r_col >= c_COL_EMIT);

   // lb[k] holds image row (row-1-k); each accept pushes the column down one buffer.
   generate
      for (genvar k = 0; k < SIZE - 1; k++) begin : g_lb
         if (k == 0) begin : g_head
            assign w_lb_wr[k] = in_data;
         end else begin : g_tail
            assign w_lb_wr[k] = w_lb_rd[k-1];
         end

         conv_line_buffer #(
            .DEPTH  (IMG_W),
            .ADDR_W (CW),
            .DATA_W (DATA_W)
         ) u_lb (
            .clk     (clk),
            .i_we    (w_accept),
            .i_addr  (r_col),
            .i_wdata (w_lb_wr[k]),
            .o_rdata (w_lb_rd[k])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (w_accept) begin
         if (w_col_wrap) begin
            r_col <= '0;
            r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + RW'(1);
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SIZE * SIZE; i++) begin
            r_win[i] <= '0;
         end
      end else if (w_accept) begin
         for (int r = 0; r < SIZE; r++) begin
            for (int c = 0; c < SIZE - 1; c++) begin
               r_win[win_idx(r, c, SIZE)] <= r_win[win_idx(r, c + 1, SIZE)];
            end
         end
         for (int r = 0; r < SIZE - 1; r++) begin
            r_win[win_idx(r, SIZE - 1, SIZE)] <= w_lb_rd[SIZE-2-r];
         end
         r_win[win_idx(SIZE - 1, SIZE - 1, SIZE)] <= in_data;
      end
   end

   // A new window takes priority over the drain of the previous one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else if (w_emit) begin
         r_valid <= 1'b1;
         r_last  <= w_frame_end;
      end else if (win_ready) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end

   assign win_valid = r_valid;
   assign win_last  = r_last;
   assign win_data  = r_win;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ---- tb_conv_window_gen : directed and randomized checks against an image-array model (rev 1.0) ----
module tb_conv_window_gen;

   localparam int SIZE  = 3;
   localparam int IMG_W = 5;
   localparam int IMG_H = 4;
   localparam int DW    = 32;
   localparam int NW    = SIZE * SIZE;

   typedef logic [DW-1:0] px_t;
   typedef struct {
      px_t  px [NW];
      logic last;
   } win_t;

   logic    clk;
   logic    rst;
   logic    in_valid;
   logic    in_ready;
   logic [DW-1:0] in_data;
   logic    win_valid;
   logic    win_ready;
   logic [DW-1:0] win_data [NW];
   logic    win_last;

   int checks = 0;
   int errors = 0;

   win_t wq[$];
   win_t dlog[$];
   px_t  img [IMG_H][IMG_W];
   int   m_row = 0;
   int   m_col = 0;

   int c_first   [NW] = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
   int c_row3a   [NW] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
   int c_row3b   [NW] = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
   int c_lastw   [NW] = '{8, 9, 10, 13, 14, 15, 18, 19, 20};
   int c_f2first [NW] = '{21, 22, 23, 26, 27, 28, 31, 32, 33};

   conv_window_gen #(
      .SIZE   (SIZE),
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .DATA_W (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_data  (win_data),
      .win_last  (win_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive at negedge, sample 1 ns later, update model for the coming posedge.
   task automatic step(input bit v, input logic [31:0] d, input bit wr, output bit acc);
      bit exp_rdy;
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      win_ready = wr;
      #1;
      exp_rdy = (wq.size() == 0) || wr;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("win_valid", 32'(win_valid), 32'(wq.size() != 0));
      if (wq.size() != 0) begin
         for (int i = 0; i < NW; i++) begin
            check($sformatf("win_data[%0d]", i), win_data[i], wq[0].px[i]);
         end
         check("win_last", 32'(win_last), 32'(wq[0].last));
         if (wr) begin
            win_t got;
            for (int i = 0; i < NW; i++) got.px[i] = win_data[i];
            got.last = win_last;
            dlog.push_back(got);
            void'(wq.pop_front());
         end
      end
      acc = v && exp_rdy;
      if (acc) begin
         img[m_row][m_col] = d;
         if (m_row >= SIZE - 1 && m_col >= SIZE - 1) begin
            win_t w;
            for (int i = 0; i < SIZE; i++)
               for (int j = 0; j < SIZE; j++)
                  w.px[i*SIZE+j] = img[m_row-SIZE+1+i][m_col-SIZE+1+j];
            w.last = (m_row == IMG_H - 1) && (m_col == IMG_W - 1);
            wq.push_back(w);
         end
         if (m_col == IMG_W - 1) begin
            m_col = 0;
            m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
         end else begin
            m_col++;
         end
      end
   endtask

   task automatic feed_seq(input int first, input int n, input int idle, input bit rnd);
      int sent  = 0;
      int guard = 0;
      bit acc;
      bit v;
      bit wr;
      logic [31:0] d;
      d = rnd ? $urandom : 32'(first);
      while (sent < n && guard < n * 20 + 50) begin
         v  = ($urandom_range(99) >= idle);
         wr = ($urandom_range(99) >= idle);
         step(v, d, wr, acc);
         if (acc) begin
            sent++;
            d = rnd ? $urandom : 32'(first + sent);
         end
         guard++;
      end
      check("feed_done", 32'(sent), 32'(n));
   endtask

   task automatic drain(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, acc);
   endtask

   task automatic check_const(input string tag, input int idx, input int v[NW]);
      if (idx >= dlog.size()) begin
         check({tag, "_missing"}, 32'(dlog.size()), 32'(idx + 1));
      end else begin
         for (int i = 0; i < NW; i++)
            check($sformatf("%s[%0d]", tag, i), dlog[idx].px[i], 32'(v[i]));
      end
   endtask

   task automatic check_last(input string tag, input int idx, input bit exp);
      if (idx >= dlog.size()) check({tag, "_missing"}, 32'(dlog.size()), 32'(idx + 1));
      else                    check(tag, 32'(dlog[idx].last), 32'(exp));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      win_ready = 1'b0;
      #1;
      check("rst_win_valid", 32'(win_valid), 32'd0);
      check("rst_win_last", 32'(win_last), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < NW; i++) check($sformatf("rst_win_data[%0d]", i), win_data[i], 32'd0);
      wq.delete();
      m_row = 0;
      m_col = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit acc;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      win_ready = 1'b0;
      apply_reset();

      // Basic frame, including the rows that wrap past the left border.
      dlog.delete();
      feed_seq(1, 20, 0, 1'b0);
      drain(3);
      check("basic_count", 32'(dlog.size()), 32'd6);
      check_const("basic_first", 0, c_first);
      check_last("basic_first_last", 0, 1'b0);
      check_const("wrap_row3a", 3, c_row3a);
      check_const("wrap_row3b", 4, c_row3b);
      check_const("basic_lastw", 5, c_lastw);
      check_last("basic_last_flag", 5, 1'b1);

      // Backpressure on the first window of the next frame.
      dlog.delete();
      feed_seq(1, 13, 0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 32'd14, 1'b0, acc);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         for (int i = 0; i < NW; i++)
            check($sformatf("bp_hold[%0d]", i), win_data[i], 32'(c_first[i]));
      end
      feed_seq(14, 7, 0, 1'b0);
      drain(3);
      check("bp_count", 32'(dlog.size()), 32'd6);
      check_const("bp_first", 0, c_first);
      check_const("bp_lastw", 5, c_lastw);

      // Two frames back to back.
      dlog.delete();
      feed_seq(1, 40, 0, 1'b0);
      drain(3);
      check("b2b_count", 32'(dlog.size()), 32'd12);
      check_last("b2b_f1_last", 5, 1'b1);
      check_const("b2b_f2_first", 6, c_f2first);
      check_last("b2b_f2_first_last", 6, 1'b0);
      check_last("b2b_f2_last", 11, 1'b1);

      // Reset part way through a frame, then a clean frame.
      feed_seq(1, 14, 0, 1'b0);
      apply_reset();
      dlog.delete();
      feed_seq(1, 20, 0, 1'b0);
      drain(3);
      check("rstmid_count", 32'(dlog.size()), 32'd6);
      check_const("rstmid_first", 0, c_first);
      check_const("rstmid_lastw", 5, c_lastw);
      check_last("rstmid_last_flag", 5, 1'b1);

      // Random data with idle cycles on both sides over three frames.
      dlog.delete();
      feed_seq(0, 3 * IMG_W * IMG_H, 20, 1'b1);
      drain(5);
      check("rand_count", 32'(dlog.size()), 32'd18);
      check_last("rand_last0", 5, 1'b1);
      check_last("rand_last1", 11, 1'b1);
      check_last("rand_last2", 17, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
